// File: rtl/cla_addsub_bist_if.sv
// Operand/result bundle between the BIST engine and the 4-bit CLA
// adder/subtractor. The engine is the master: it drives A/B/M and
// observes S/Cout. The adder side uses the slave modport.
interface cla_addsub_bist_if;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_m;
  logic [3:0] dut_s;
  logic       dut_cout;

  modport master (
    output dut_a,
    output dut_b,
    output dut_m,
    input  dut_s,
    input  dut_cout
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_m,
    output dut_s,
    output dut_cout
  );
endinterface

// File: rtl/cla_addsub_bist.sv
// Built-in self-test engine for the 4-bit carry-lookahead adder/subtractor.
// Walks all 512 {M,A,B} vectors in order (M most significant), holds each
// vector for SETTLE cycles, compares {Cout,S} against a golden model,
// counts mismatches (saturating) and captures the first failing vector.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// DRIVE  | load dut_a/b/m from the vector index (1 cycle)
// WAIT   | hold vector stable for SETTLE cycles (skipped when SETTLE==0)
// CHECK  | compare adder outputs with golden, step index or finish
// DONE   | sweep finished, result presented until the next start
module cla_addsub_bist #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  cla_addsub_bist_if.master     dut_if,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ERR_W-1:0]      o_err_count,
  output logic                  o_fail_valid,
  output logic [3:0]            o_fail_a,
  output logic [3:0]            o_fail_b,
  output logic                  o_fail_m
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // WAIT is a down-counter that exits on terminal count zero, so it is
  // loaded with SETTLE-1 to give exactly SETTLE cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [8:0] LAST_IDX  = 9'h1FF;

  logic [2:0]       r_state;
  logic [8:0]       r_idx;
  logic [3:0]       r_wait_cnt;
  logic [3:0]       r_dut_a;
  logic [3:0]       r_dut_b;
  logic             r_dut_m;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [3:0]       r_fail_a;
  logic [3:0]       r_fail_b;
  logic             r_fail_m;
  logic             r_pass;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_state_nxt;
  logic             w_start_sweep;
  logic             w_last;
  logic [3:0]       w_b_eff;
  logic [4:0]       w_gold;
  logic             w_mismatch;
  logic             w_err_sat;
  logic [ERR_W-1:0] w_err_next;

  assign w_last = (r_idx == LAST_IDX);

  // Golden model: subtract is A + ~B + 1, so Cout=1 means no borrow.
  assign w_b_eff    = r_dut_m ? ~r_dut_b : r_dut_b;
  assign w_gold     = {1'b0, r_dut_a} + {1'b0, w_b_eff} + {4'd0, r_dut_m};
  assign w_mismatch = ({dut_if.dut_cout, dut_if.dut_s} != w_gold);
  assign w_err_sat  = &r_err;
  assign w_err_next = (w_mismatch && !w_err_sat) ? (r_err + ERR_W'(1)) : r_err;

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_sweep = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt   = ST_DRIVE;
          w_start_sweep = 1'b1;
        end
      end
      ST_DRIVE: begin
        w_state_nxt = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_WAIT) ||
                 (w_state_nxt == ST_CHECK);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Vector index: cleared on start, stepped after each non-final CHECK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= 9'd0;
    end else if (w_start_sweep) begin
      r_idx <= 9'd0;
    end else if ((r_state == ST_CHECK) && !w_last) begin
      r_idx <= r_idx + 9'd1;
    end
  end

  // Settle timer: loaded in DRIVE, counts down to terminal count in WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == ST_DRIVE) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Operand drive: the vector is launched in DRIVE and held until the
  // next DRIVE, so it stays put through DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dut_a <= 4'd0;
      r_dut_b <= 4'd0;
      r_dut_m <= 1'b0;
    end else if (r_state == ST_DRIVE) begin
      r_dut_m <= r_idx[8];
      r_dut_a <= r_idx[7:4];
      r_dut_b <= r_idx[3:0];
    end
  end

  // Result tracking: error count, first-failure capture and pass flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= 4'd0;
      r_fail_b     <= 4'd0;
      r_fail_m     <= 1'b0;
      r_pass       <= 1'b0;
    end else if (w_start_sweep) begin
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= 4'd0;
      r_fail_b     <= 4'd0;
      r_fail_m     <= 1'b0;
      r_pass       <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_err <= w_err_next;
      if (w_mismatch && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_a     <= r_dut_a;
        r_fail_b     <= r_dut_b;
        r_fail_m     <= r_dut_m;
      end
      if (w_last) begin
        r_pass <= (w_err_next == '0);
      end
    end
  end

  assign dut_if.dut_a = r_dut_a;
  assign dut_if.dut_b = r_dut_b;
  assign dut_if.dut_m = r_dut_m;

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_a     = r_fail_a;
  assign o_fail_b     = r_fail_b;
  assign o_fail_m     = r_fail_m;

endmodule

// File: tb/tb_cla_addsub_bist.sv
// Bench for cla_addsub_bist: two engines (SETTLE=1/ERR_W=10 and
// SETTLE=0/ERR_W=4) each drive a behavioural adder with selectable faults.
// Expected sweep results are queued at start; monitors pop on done.
module tb_cla_addsub_bist;

  typedef struct {
    int len;
    int err;
    int fv;
    int fa;
    int fb;
    int fm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n1, rst_n2, start1, start2;
  int   fault1, fault2;
  logic [8:0] fvec;
  logic [4:0] fmask;

  logic       busy1, done1, pass1, fv1, fm1;
  logic [9:0] err1;
  logic [3:0] fa1, fb1;
  logic       busy2, done2, pass2, fv2, fm2;
  logic [3:0] err2;
  logic [3:0] fa2, fb2;

  int tests = 0;
  int fails = 0;
  exp_t q1[$];
  exp_t q2[$];

  cla_addsub_bist_if bus1();
  cla_addsub_bist_if bus2();

  // Adder model: 0 good, 1 S[0] stuck 0, 2 Cout inverted in subtract,
  // 3 every output bit inverted, 4 one vector corrupted by a mask.
  function automatic logic [4:0] adder_model(input int fault, input logic [8:0] v,
                                             input logic [8:0] fv, input logic [4:0] fm);
    int a, b, r;
    logic [4:0] o;
    a = int'(v[7:4]);
    b = int'(v[3:0]);
    r = v[8] ? (a + 16 - b) : (a + b);
    o = 5'(r);
    case (fault)
      1: o[0] = 1'b0;
      2: if (v[8]) o[4] = ~o[4];
      3: o = ~o;
      4: if (v == fv) o = o ^ fm;
      default: ;
    endcase
    return o;
  endfunction

  assign {bus1.dut_cout, bus1.dut_s} =
    adder_model(fault1, {bus1.dut_m, bus1.dut_a, bus1.dut_b}, fvec, fmask);
  assign {bus2.dut_cout, bus2.dut_s} =
    adder_model(fault2, {bus2.dut_m, bus2.dut_a, bus2.dut_b}, fvec, fmask);

  cla_addsub_bist #(.SETTLE(1), .ERR_W(10)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n1), .i_start(start1), .dut_if(bus1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
    .o_fail_valid(fv1), .o_fail_a(fa1), .o_fail_b(fb1), .o_fail_m(fm1)
  );

  cla_addsub_bist #(.SETTLE(0), .ERR_W(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n2), .i_start(start2), .dut_if(bus2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_count(err2),
    .o_fail_valid(fv2), .o_fail_a(fa2), .o_fail_b(fb2), .o_fail_m(fm2)
  );

  // Whole-sweep reference: plain arithmetic golden vs. the adder model.
  function automatic exp_t ref_sweep(input int fault, input int err_w, input int settle,
                                     input logic [8:0] fv, input logic [4:0] fm);
    exp_t e;
    int errs, a, b, m, gold, got, cap;
    e.len = 512 * (settle + 2);
    e.fv = 0; e.fa = 0; e.fb = 0; e.fm = 0;
    errs = 0;
    for (int v = 0; v < 512; v++) begin
      m = v / 256;
      a = (v / 16) % 16;
      b = v % 16;
      if (m == 0) gold = a + b;
      else gold = ((a - b + 16) % 16) + ((a >= b) ? 16 : 0);
      got = int'(adder_model(fault, 9'(v), fv, fm));
      if (got != gold) begin
        errs++;
        if (e.fv == 0) begin
          e.fv = 1; e.fa = a; e.fb = b; e.fm = m;
        end
      end
    end
    cap = (1 << err_w) - 1;
    e.err = (errs > cap) ? cap : errs;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sweep_cmp(input string tag, input exp_t e, input int len, input int pass,
                           input int err, input int fv, input int fa, input int fb, input int fm);
    chk({tag, " busy length"}, len, e.len);
    chk({tag, " pass"}, pass, (e.err == 0) ? 1 : 0);
    chk({tag, " err_count"}, err, e.err);
    chk({tag, " fail_valid"}, fv, e.fv);
    chk({tag, " fail_a"}, fa, e.fa);
    chk({tag, " fail_b"}, fb, e.fb);
    chk({tag, " fail_m"}, fm, e.fm);
  endtask

  int   cnt1, cnt2;
  logic pd1, pd2;
  exp_t e1, e2;

  always @(negedge clk) begin
    if (!rst_n1) begin
      cnt1 = 0; pd1 = 1'b0;
    end else begin
      if (busy1) cnt1++;
      if (!done1) chk("dut1 pass low while not done", int'(pass1), 0);
      if (done1 && !pd1) begin
        if (q1.size() == 0) chk("dut1 done with expectation queued", q1.size(), 1);
        else begin
          e1 = q1.pop_front();
          sweep_cmp("dut1", e1, cnt1, int'(pass1), int'(err1), int'(fv1),
                    int'(fa1), int'(fb1), int'(fm1));
        end
        cnt1 = 0;
      end
      pd1 = done1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n2) begin
      cnt2 = 0; pd2 = 1'b0;
    end else begin
      if (busy2) cnt2++;
      if (!done2) chk("dut2 pass low while not done", int'(pass2), 0);
      if (done2 && !pd2) begin
        if (q2.size() == 0) chk("dut2 done with expectation queued", q2.size(), 1);
        else begin
          e2 = q2.pop_front();
          sweep_cmp("dut2", e2, cnt2, int'(pass2), int'(err2), int'(fv2),
                    int'(fa2), int'(fb2), int'(fm2));
        end
        cnt2 = 0;
      end
      pd2 = done2;
    end
  end

  task automatic check_zero(input int d);
    if (d == 1)
      chk("dut1 outputs zero in reset",
          int'({busy1, done1, pass1, err1, fv1, fa1, fb1, fm1,
                bus1.dut_a, bus1.dut_b, bus1.dut_m}), 0);
    else
      chk("dut2 outputs zero in reset",
          int'({busy2, done2, pass2, err2, fv2, fa2, fb2, fm2,
                bus2.dut_a, bus2.dut_b, bus2.dut_m}), 0);
  endtask

  task automatic pulse(input int d);
    @(negedge clk);
    if (d == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic push_exp(input int d, input int fault);
    if (d == 1) begin
      fault1 = fault;
      q1.push_back(ref_sweep(fault, 10, 1, fvec, fmask));
    end else begin
      fault2 = fault;
      q2.push_back(ref_sweep(fault, 4, 0, fvec, fmask));
    end
  endtask

  task automatic wait_done(input int d, input int bound);
    int  n;
    bit  ok;
    n = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      @(negedge clk);
      n++;
      ok = (d == 1) ? done1 : done2;
    end
    chk("sweep finished within cycle budget", int'(ok), 1);
    @(negedge clk);
  endtask

  task automatic run_sweep(input int d, input int fault, input int extra_at);
    push_exp(d, fault);
    pulse(d);
    if (d == 1) begin
      chk("dut1 busy after start", int'(busy1), 1);
      chk("dut1 results cleared on start", int'({err1, fv1, done1}), 0);
    end else begin
      chk("dut2 busy after start", int'(busy2), 1);
      chk("dut2 results cleared on start", int'({err2, fv2, done2}), 0);
    end
    if (extra_at > 2) begin
      repeat (extra_at - 2) @(negedge clk);
      pulse(d);
    end
    wait_done(d, (d == 1) ? 1700 : 1200);
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  task automatic reset_mid(input int d);
    push_exp(d, 0);
    pulse(d);
    repeat (698) @(negedge clk);
    if (d == 1) rst_n1 = 1'b0; else rst_n2 = 1'b0;
    #1;
    check_zero(d);
    if (d == 1) q1.delete(); else q2.delete();
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1;
    rst_n2 = 1'b1;
    @(negedge clk);
    check_zero(d);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n1 = 1'b0; rst_n2 = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    fault1 = 0; fault2 = 0;
    fvec = 9'd0; fmask = 5'd0;
    repeat (3) @(negedge clk);
    check_zero(1);
    check_zero(2);
    rst_n1 = 1'b1; rst_n2 = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(1, 0, 0);
    run_sweep(1, 1, 0);
    run_sweep(1, 0, 0);
    run_sweep(1, 2, 0);
    for (int k = 0; k < 2; k++) begin
      fvec  = 9'($urandom_range(0, 511));
      fmask = 5'($urandom_range(1, 31));
      run_sweep(1, 4, 0);
    end
    run_sweep(1, 0, 100);
    run_sweep(1, 1, $urandom_range(20, 1400));
    reset_mid(1);
    run_sweep(1, 0, 0);

    run_sweep(2, 3, 0);
    run_sweep(2, 0, 0);
    reset_mid(2);
    run_sweep(2, 0, 0);

    repeat (4) @(negedge clk);
    chk("dut1 no pending expectations", q1.size(), 0);
    chk("dut2 no pending expectations", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
